// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sonar_pkg
//  Description : Shared definitions for the multi-channel sonar ranging
//                engine: FSM state encoding, channel-index width helper and
//                default timing constants (all timing in 1 us clock cycles).
//  Revision    : 1.0  initial release
// ============================================================================
package sonar_pkg;

    // Ranging FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEL       = 3'd1,
        ST_TRIG      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_MEAS      = 3'd4,
        ST_HOLD      = 3'd5,
        ST_GAP       = 3'd6
    } state_t;

    // Default timing in microseconds (one clk_1m cycle each).
    localparam int C_TRIG_US    = 10;
    localparam int C_TIMEOUT_US = 30000;
    localparam int C_GAP_US     = 60000;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : sonar_pkg
`default_nettype wire

// File: rtl/sonar_scan_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sonar_scan_if
//  Description : Result channel of the sonar ranging engine (valid/ready).
//                master = ranging engine, slave = reporting path.
//  Signals     : res_vld  - result valid
//                res_rdy  - result accepted when res_vld && res_rdy
//                res_ch   - channel the result belongs to
//                res_us   - echo high width in us
//                res_to   - timeout / stuck-echo flag
//  Revision    : 1.0  initial release
// ============================================================================
interface sonar_scan_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             res_vld;
    logic             res_rdy;
    logic [CH_W-1:0]  res_ch;
    logic [CNT_W-1:0] res_us;
    logic             res_to;

    modport master (
        output res_vld,
        output res_ch,
        output res_us,
        output res_to,
        input  res_rdy
    );

    modport slave (
        input  res_vld,
        input  res_ch,
        input  res_us,
        input  res_to,
        output res_rdy
    );
endinterface : sonar_scan_if
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser bank for asynchronous inputs,
//                cleared by synchronous reset.
//  Ports       : clk  - destination clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous inputs (WIDTH bits)
//                o_q  - synchronised outputs (two cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/sonar_scan.sv
`default_nettype none
// ============================================================================
//  Module      : sonar_scan
//  Description : Round-robin ranging engine for N_CH HC-SR04-style sensors.
//                Per ping: TRIG_US trigger pulse, wait for echo rise, time
//                echo width in us, present result on a valid/ready channel,
//                then GAP_US of dead time before the next channel.
//  Ports       : clk_1m    - 1 MHz clock (1 cycle = 1 us)
//                rst       - synchronous active-high reset
//                start     - pulse; begins a scan when idle
//                mode_cont - rescan continuously (sampled at end of round)
//                ch_en     - per-channel enable (sampled at channel select)
//                s_trig    - sensor triggers, at most one high
//                s_echo    - asynchronous sensor echoes
//                res       - result channel (master side)
//                busy      - high whenever not idle
//  Revision    : 1.0  initial release
// ============================================================================
module sonar_scan
    import sonar_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int TRIG_US    = C_TRIG_US,
    parameter int TIMEOUT_US = C_TIMEOUT_US,
    parameter int GAP_US     = C_GAP_US
) (
    input  wire logic            clk_1m,
    input  wire logic            rst,
    input  wire logic            start,
    input  wire logic            mode_cont,
    input  wire logic [N_CH-1:0] ch_en,
    output logic      [N_CH-1:0] s_trig,
    input  wire logic [N_CH-1:0] s_echo,
    sonar_scan_if.master         res,
    output logic                 busy
);

    localparam int CH_W    = ch_width(N_CH);
    // Pointer is one bit wider so "past the last channel" is representable.
    localparam int PTR_W   = CH_W + 1;
    localparam int TMR_MAX = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] C_TRIG_LAST    = TMR_W'(TRIG_US - 1);
    localparam logic [TMR_W-1:0] C_GAP_LAST     = TMR_W'(GAP_US - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT      = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);

    state_t            r_state, w_state_nxt;
    logic [PTR_W-1:0]  r_ptr,   w_ptr_nxt;
    logic [CH_W-1:0]   r_ch,    w_ch_nxt;
    logic [TMR_W-1:0]  r_tmr,   w_tmr_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_vld,   w_vld_nxt;
    logic [CNT_W-1:0]  r_us,    w_us_nxt;
    logic              r_to,    w_to_nxt;

    logic [N_CH-1:0]   w_echo_sync;
    logic              w_echo;
    logic              w_found;
    logic [CH_W-1:0]   w_pick;

    sync2 #(
        .WIDTH (N_CH)
    ) u_sync2 (
        .clk (clk_1m),
        .rst (rst),
        .i_d (s_echo),
        .o_q (w_echo_sync)
    );

    // Only the channel currently being pinged is observed.
    assign w_echo = w_echo_sync[r_ch];

    // Lowest enabled channel at or above the round pointer. Scanning from
    // the top down lets the lowest match be the last one written.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_en[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_pick  = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk_1m) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_ch    <= '0;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_us    <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ch    <= w_ch_nxt;
            r_tmr   <= w_tmr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vld   <= w_vld_nxt;
            r_us    <= w_us_nxt;
            r_to    <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ch_nxt    = r_ch;
        w_tmr_nxt   = r_tmr;
        w_cnt_nxt   = r_cnt;
        w_vld_nxt   = r_vld;
        w_us_nxt    = r_us;
        w_to_nxt    = r_to;

        case (r_state)
            ST_IDLE: begin
                if (start && (ch_en != '0)) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = ST_SEL;
                end
            end

            ST_SEL: begin
                if (w_found) begin
                    w_ch_nxt    = w_pick;
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_TRIG;
                end else if (mode_cont && (ch_en != '0)) begin
                    // End of round, rescan from channel 0 next cycle.
                    w_ptr_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_TRIG: begin
                if (r_tmr == C_TRIG_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT_RISE;
                end else begin
                    w_tmr_nxt   = r_tmr + 1'b1;
                end
            end

            ST_WAIT_RISE: begin
                if (w_echo) begin
                    // Rise cycle already counts as the first us of echo.
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_MEAS;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_vld_nxt   = 1'b1;
                    w_us_nxt    = '0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            ST_MEAS: begin
                if (!w_echo) begin
                    w_vld_nxt   = 1'b1;
                    w_us_nxt    = r_cnt;
                    w_to_nxt    = 1'b0;
                    w_state_nxt = ST_HOLD;
                end else if (r_cnt == C_TIMEOUT) begin
                    // Echo stuck high: report the saturated width.
                    w_vld_nxt   = 1'b1;
                    w_us_nxt    = C_TIMEOUT;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                if (res.res_rdy) begin
                    w_vld_nxt   = 1'b0;
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                if (r_tmr == C_GAP_LAST) begin
                    w_ptr_nxt   = {1'b0, r_ch} + PTR_W'(1);
                    w_state_nxt = ST_SEL;
                end else begin
                    w_tmr_nxt   = r_tmr + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_trig      = (r_state == ST_TRIG) ? (N_CH'(1) << r_ch) : '0;
    assign busy        = (r_state != ST_IDLE);
    assign res.res_vld = r_vld;
    assign res.res_ch  = r_ch;
    assign res.res_us  = r_us;
    assign res.res_to  = r_to;

endmodule : sonar_scan
`default_nettype wire
